// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions used by the processor initiators and
// by memory_subsystem.
package mem_if_pkg;

  localparam int unsigned MEM_ADDR_W = 14;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_t;

  // Canonical command word at the default 16-bit data width.
  typedef struct packed {
    mem_op_t                 op;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
  } mem_cmd_t;

  // Line coherency state, shared with memory_subsystem.
  typedef enum logic [1:0] {
    COH_INVALID   = 2'd0,
    COH_SHARED    = 2'd1,
    COH_EXCLUSIVE = 2'd2,
    COH_MODIFIED  = 2'd3
  } coherency_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and show-ahead read data.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/proc_mem_initiator.sv
// Processor-side initiator: queues core load/store commands and issues them
// one at a time on the memory port, returning load data or a timeout error.
module proc_mem_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [MEM_ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_SIZE*8-1:0]  cmd_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_write,
  output logic [DATA_SIZE*8-1:0]  rsp_data,
  output logic                    rsp_error,
  output logic                    processor_req,
  output logic                    mem_read_req,
  output logic                    mem_write_req,
  output logic [MEM_ADDR_W-1:0]   addr,
  output logic [DATA_SIZE*8-1:0]  mem_write_data,
  input  logic [DATA_SIZE*8-1:0]  mem_read_data,
  input  logic                    processor_resp
);

  localparam int unsigned DW = DATA_SIZE * 8;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIMIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } init_state_t;

  // Same layout as mem_cmd_t, but with the data field sized by DATA_SIZE.
  typedef struct packed {
    mem_op_t               op;
    logic [MEM_ADDR_W-1:0] addr;
    logic [DW-1:0]         wdata;
  } cmd_entry_t;

  init_state_t                state;
  logic [TW-1:0]              tcnt;
  cmd_entry_t                 in_entry;
  cmd_entry_t                 head;
  logic [$bits(cmd_entry_t)-1:0] head_bits;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       timeout_hit;

  assign in_entry.op    = cmd_write ? MEM_WR : MEM_RD;
  assign in_entry.addr  = cmd_addr;
  assign in_entry.wdata = cmd_wdata;
  assign head           = cmd_entry_t'(head_bits);

  assign cmd_ready   = !fifo_full;
  assign fifo_push   = cmd_valid && !fifo_full;
  assign fifo_pop    = (state == IDLE) && !fifo_empty;
  assign timeout_hit = TO_EN && (tcnt == TLIMIT);

  sync_fifo #(
    .WIDTH ($bits(cmd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (in_entry),
    .pop     (fifo_pop),
    .rdata   (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue FSM with registered memory-port and response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      tcnt           <= '0;
      processor_req  <= 1'b0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      addr           <= '0;
      mem_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state          <= REQ;
            tcnt           <= '0;
            processor_req  <= 1'b1;
            mem_read_req   <= (head.op == MEM_RD);
            mem_write_req  <= (head.op == MEM_WR);
            addr           <= head.addr;
            mem_write_data <= head.wdata;
          end
        end
        REQ: begin
          // A response on the timeout edge still counts as a normal completion.
          if (processor_resp || timeout_hit) begin
            state          <= GAP;
            processor_req  <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            addr           <= '0;
            mem_write_data <= '0;
            rsp_valid      <= 1'b1;
            rsp_write      <= mem_write_req;
            rsp_error      <= !processor_resp;
            rsp_data       <= (processor_resp && mem_read_req) ? mem_read_data : '0;
          end else if (TO_EN) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mem_initiator.sv
// Directed bench for proc_mem_initiator with a latency-programmable memory
// model and an in-order response scoreboard.
module tb_proc_mem_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        processor_req;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        processor_resp;

  always #5 clk = ~clk;

  proc_mem_initiator #(
    .DATA_SIZE  (2),
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_write      (rsp_write),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .processor_req  (processor_req),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .addr           (addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .processor_resp (processor_resp)
  );

  int total = 0;
  int bad   = 0;

  logic [17:0] q[$];               // {write, data, error}
  logic [15:0] model_mem [16384];  // memory behind the port
  logic [15:0] ref_mem   [16384];  // bench expectation of memory contents
  int          delay = 0;
  bit          mute  = 1'b0;
  int          wait_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, score any response, then run the memory model.
  task automatic tick();
    logic [17:0] e;
    @(negedge clk);
    if (rsp_valid === 1'b1) begin
      chk("rsp_pending", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp", {rsp_write, rsp_data, rsp_error}, e);
      end
    end
    if (!reset_n) begin
      wait_cnt       = 0;
      processor_resp = 1'b0;
    end else if (processor_req && !mute) begin
      if (wait_cnt == delay) begin
        processor_resp = 1'b1;
        wait_cnt       = 0;
        if (mem_write_req) model_mem[addr] = mem_write_data;
        else               mem_read_data   = model_mem[addr];
      end else begin
        processor_resp = 1'b0;
        wait_cnt++;
      end
    end else begin
      processor_resp = 1'b0;
      wait_cnt       = 0;
    end
  endtask

  task automatic send(input logic w, input logic [13:0] a, input logic [15:0] d,
                      input logic err, output int waited);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    waited    = 0;
    while (cmd_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    chk("cmd_accept", 32'(cmd_ready), 1);
    if (w && !err) ref_mem[a] = d;
    q.push_back({w, (w || err) ? 16'h0000 : ref_mem[a], err});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    int w;
    int n;
    for (int i = 0; i < 16384; i++) begin
      model_mem[i] = 16'(i + 1);
      ref_mem[i]   = 16'(i + 1);
    end
    reset_n        = 1'b0;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_addr       = '0;
    cmd_wdata      = '0;
    mem_read_data  = '0;
    processor_resp = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state
    chk("rst_req", {29'd0, processor_req, mem_read_req, mem_write_req}, 0);
    chk("rst_addr_wd", {addr, mem_write_data}, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_error, rsp_data}, 0);
    chk("rst_ready", 32'(cmd_ready), 1);

    // Single load, memory answers on the first REQ cycle
    delay = 0;
    send(1'b0, 14'd5, 16'h0, 1'b0, w);
    tick();
    chk("ld_req", {processor_req, mem_read_req, mem_write_req}, 3'b110);
    chk("ld_addr", 32'(addr), 5);
    tick();
    chk("ld_rsp_valid", 32'(rsp_valid), 1);
    chk("ld_req_drop", 32'(processor_req), 0);
    tick();
    chk("ld_rsp_pulse", 32'(rsp_valid), 0);
    chk("ld_q_empty", q.size(), 0);

    // Store then load the same word
    send(1'b1, 14'd3, 16'hBEEF, 1'b0, w);
    send(1'b0, 14'd3, 16'h0, 1'b0, w);
    chk("st_req", {processor_req, mem_read_req, mem_write_req}, 3'b101);
    chk("st_wdata", {addr, mem_write_data}, {14'd3, 16'hBEEF});
    tick();
    chk("st_gap1", 32'(processor_req), 0);
    tick();
    chk("st_gap2", 32'(processor_req), 0);
    tick();
    chk("st_ld_req", {processor_req, mem_read_req, addr}, {1'b1, 1'b1, 14'd3});
    drain(20);

    // FIFO full: one in flight plus four queued, sixth held until a pop
    delay = 12;
    send(1'b0, 14'd10, 16'h0,    1'b0, w);
    send(1'b0, 14'd11, 16'h0,    1'b0, w);
    send(1'b1, 14'd20, 16'h1234, 1'b0, w);
    send(1'b0, 14'd20, 16'h0,    1'b0, w);
    send(1'b0, 14'd12, 16'h0,    1'b0, w);
    chk("full_ready_low", 32'(cmd_ready), 0);
    send(1'b0, 14'd20, 16'h0, 1'b0, w);
    chk("full_hold_cycles", w, 12);
    drain(400);

    // Timeout on the first command, second issues normally
    delay = 0;
    mute  = 1'b1;
    send(1'b0, 14'd30, 16'h0, 1'b1, w);
    send(1'b0, 14'd31, 16'h0, 1'b0, w);
    n = 0;
    while (processor_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 16);
    mute = 1'b0;
    drain(40);

    // Response on the same edge as the timeout completes normally
    delay = 15;
    send(1'b0, 14'd7, 16'h0, 1'b0, w);
    tick();
    n = 0;
    while (processor_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("co_req_cycles", n, 16);
    drain(40);

    // Reset during REQ with two commands queued
    mute = 1'b1;
    send(1'b0, 14'd40, 16'h0, 1'b1, w);
    send(1'b0, 14'd41, 16'h0, 1'b1, w);
    send(1'b0, 14'd42, 16'h0, 1'b1, w);
    chk("mr_req_up", 32'(processor_req), 1);
    q.delete();
    reset_n = 1'b0;
    tick();
    chk("mr_req_drop", {processor_req, rsp_valid}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      processor_resp = 1'b1;
      tick();
      chk("mr_idle", {processor_req, rsp_valid, cmd_ready}, 3'b001);
    end
    processor_resp = 1'b0;
    mute  = 1'b0;
    delay = 0;
    send(1'b0, 14'd0, 16'h0, 1'b0, w);
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
